// File: rtl/box_resolver.sv
// box_resolver: sweeps one moving axis-aligned box against the tile map.
// It probes the leading edge of the horizontal pass, then the vertical pass,
// and reports sticky directional collision flags.
//
// Ports:
//   clk, rst               clock, asynchronous active-high reset
//   start                  request, accepted only while busy = 0
//   x_pos, y_pos           box bottom-left corner (y grows downward)
//   x_spd, y_spd           per-step displacement magnitude
//   x_dir                  0 = left, 1 = right
//   y_dir                  0 = down, 1 = up
//   qry_x, qry_y, qry_vld  registered map probe
//   tile_type              block type for the probe LOOKUP_LAT cycles back
//   busy, done             request in progress / one-cycle completion pulse
//   col                    [3] top, [2] right, [1] bottom, [0] left
module box_resolver #(
    parameter int POS_W      = 10,
    parameter int SPD_W      = 5,
    parameter int TYPE_W     = 3,
    parameter int BOX_W      = 32,
    parameter int BOX_H      = 32,
    parameter int NPTS_X     = 2,
    parameter int NPTS_Y     = 2,
    parameter int LOOKUP_LAT = 1,
    parameter logic [(1<<TYPE_W)-1:0] SOLID_MASK  = 'b0000_0010,
    parameter logic [(1<<TYPE_W)-1:0] ONEWAY_MASK = 'b0000_0100
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [POS_W-1:0]  x_pos,
    input  logic [POS_W-1:0]  y_pos,
    input  logic [SPD_W-1:0]  x_spd,
    input  logic [SPD_W-1:0]  y_spd,
    input  logic              x_dir,
    input  logic              y_dir,
    output logic [POS_W-1:0]  qry_x,
    output logic [POS_W-1:0]  qry_y,
    output logic              qry_vld,
    input  logic [TYPE_W-1:0] tile_type,
    output logic              busy,
    output logic              done,
    output logic [3:0]        col
);

    localparam int CNT_MAX_XY =
        (NPTS_X > NPTS_Y) ? NPTS_X : NPTS_Y;
    localparam int CNT_MAX =
        (CNT_MAX_XY > LOOKUP_LAT) ? CNT_MAX_XY : LOOKUP_LAT;
    localparam int CNT_W = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(NPTS_Y - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(NPTS_X - 1);
    localparam logic [CNT_W-1:0] LAT_LAST = CNT_W'(LOOKUP_LAT - 1);

    localparam logic [POS_W-1:0] BOX_W_M1 = POS_W'(BOX_W - 1);
    localparam logic [POS_W-1:0] BOX_H_M1 = POS_W'(BOX_H - 1);

    typedef enum logic [2:0] {
        IDLE,
        H_ISSUE,
        H_DRAIN,
        V_ISSUE,
        V_DRAIN,
        DONE
    } state_t;

    state_t           state;
    state_t           stateNext;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cntNext;

    // Request context captured at accept
    logic [POS_W-1:0] xPosR;
    logic [POS_W-1:0] yPosR;
    logic [POS_W-1:0] nxR;
    logic [POS_W-1:0] nyR;
    logic             xDirR;
    logic             yDirR;
    logic             ySpdNz;

    logic             accept;
    logic [POS_W-1:0] nxIn;
    logic [POS_W-1:0] nyIn;

    // Effective context: live inputs on the accept cycle, else registers,
    // so the first probe can be registered on the accept edge.
    logic [POS_W-1:0] xPosE;
    logic [POS_W-1:0] yPosE;
    logic [POS_W-1:0] nxE;
    logic [POS_W-1:0] nyE;
    logic             xDirE;
    logic             yDirE;

    logic             qryVldNext;
    logic             qryPassNext;
    logic [POS_W-1:0] qryXNext;
    logic [POS_W-1:0] qryYNext;
    logic             qryPass;

    // Response tracker: {valid, pass} per in-flight probe (pass 1 = vertical)
    logic [LOOKUP_LAT-1:0] trkVld;
    logic [LOOKUP_LAT-1:0] trkPass;
    logic                  emVld;
    logic                  emPass;
    logic                  hit;
    logic [3:0]            colSet;

    // Edge sample offsets, evenly spread and rounded down
    function automatic logic [POS_W-1:0] offH(
        input logic [CNT_W-1:0] k
    );
        int prod;
        prod = (BOX_H - 1) * int'(k);
        return POS_W'(prod / (NPTS_Y - 1));
    endfunction

    function automatic logic [POS_W-1:0] offV(
        input logic [CNT_W-1:0] k
    );
        int prod;
        prod = (BOX_W - 1) * int'(k);
        return POS_W'(prod / (NPTS_X - 1));
    endfunction

    assign accept = (state == IDLE) && start;

    assign nxIn = x_dir ? x_pos + POS_W'(x_spd)
                        : x_pos - POS_W'(x_spd);
    assign nyIn = y_dir ? y_pos - POS_W'(y_spd)
                        : y_pos + POS_W'(y_spd);

    assign xPosE = accept ? x_pos : xPosR;
    assign yPosE = accept ? y_pos : yPosR;
    assign nxE   = accept ? nxIn  : nxR;
    assign nyE   = accept ? nyIn  : nyR;
    assign xDirE = accept ? x_dir : xDirR;
    assign yDirE = accept ? y_dir : yDirR;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= stateNext;
            cnt   <= cntNext;
        end
    end

    // Next-state logic
    always_comb begin
        stateNext = state;
        cntNext   = cnt;
        unique case (state)
            IDLE: begin
                if (start) begin
                    cntNext = '0;
                    if (x_spd != '0)
                        stateNext = H_ISSUE;
                    else if (y_spd != '0)
                        stateNext = V_ISSUE;
                    else
                        stateNext = DONE;
                end
            end
            H_ISSUE: begin
                if (cnt == H_LAST) begin
                    cntNext   = '0;
                    stateNext = H_DRAIN;
                end else begin
                    cntNext = cnt + 1'b1;
                end
            end
            H_DRAIN: begin
                if (cnt == LAT_LAST) begin
                    cntNext   = '0;
                    stateNext = ySpdNz ? V_ISSUE : DONE;
                end else begin
                    cntNext = cnt + 1'b1;
                end
            end
            V_ISSUE: begin
                if (cnt == V_LAST) begin
                    cntNext   = '0;
                    stateNext = V_DRAIN;
                end else begin
                    cntNext = cnt + 1'b1;
                end
            end
            V_DRAIN: begin
                if (cnt == LAT_LAST) begin
                    cntNext   = '0;
                    stateNext = DONE;
                end else begin
                    cntNext = cnt + 1'b1;
                end
            end
            DONE: begin
                stateNext = IDLE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    // Output logic: status flags and the probe for the upcoming cycle
    always_comb begin
        busy        = (state != IDLE);
        done        = (state == DONE);
        qryVldNext  = 1'b0;
        qryPassNext = 1'b0;
        qryXNext    = '0;
        qryYNext    = '0;
        unique case (1'b1)
            (stateNext == H_ISSUE): begin
                qryVldNext = 1'b1;
                qryXNext   = xDirE ? nxE + BOX_W_M1 : nxE;
                qryYNext   = yPosE - offH(cntNext);
            end
            (stateNext == V_ISSUE): begin
                qryVldNext  = 1'b1;
                qryPassNext = 1'b1;
                qryXNext    = xPosE + offV(cntNext);
                qryYNext    = yDirE ? nyE - BOX_H_M1 : nyE;
            end
            default: begin
            end
        endcase
    end

    assign emVld  = trkVld[LOOKUP_LAT-1];
    assign emPass = trkPass[LOOKUP_LAT-1];

    // One-way blocks only stop a box falling onto them
    assign hit = emVld &&
        (SOLID_MASK[tile_type] ||
         (ONEWAY_MASK[tile_type] && emPass && !yDirR));

    always_comb begin
        colSet = '0;
        if (hit) begin
            if (emPass)
                colSet = yDirR ? 4'b1000 : 4'b0010;
            else
                colSet = xDirR ? 4'b0100 : 4'b0001;
        end
    end

    // Datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            xPosR   <= '0;
            yPosR   <= '0;
            nxR     <= '0;
            nyR     <= '0;
            xDirR   <= 1'b0;
            yDirR   <= 1'b0;
            ySpdNz  <= 1'b0;
            qry_vld <= 1'b0;
            qryPass <= 1'b0;
            qry_x   <= '0;
            qry_y   <= '0;
            trkVld  <= '0;
            trkPass <= '0;
            col     <= '0;
        end else begin
            if (accept) begin
                xPosR  <= x_pos;
                yPosR  <= y_pos;
                nxR    <= nxIn;
                nyR    <= nyIn;
                xDirR  <= x_dir;
                yDirR  <= y_dir;
                ySpdNz <= (y_spd != '0);
            end
            qry_vld <= qryVldNext;
            qryPass <= qryPassNext;
            qry_x   <= qryXNext;
            qry_y   <= qryYNext;
            trkVld[0]  <= qry_vld;
            trkPass[0] <= qryPass;
            for (int i = 1; i < LOOKUP_LAT; i++) begin
                trkVld[i]  <= trkVld[i-1];
                trkPass[i] <= trkPass[i-1];
            end
            if (accept)
                col <= '0;
            else
                col <= col | colSet;
        end
    end

endmodule

// File: tb/tb_box_resolver.sv
// tb_box_resolver: directed scoreboard bench for box_resolver.
// A default instance and a deeper-latency instance share clock and reset.
module tb_box_resolver;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic       startA;
    logic [9:0] xPosA, yPosA;
    logic [4:0] xSpdA, ySpdA;
    logic       xDirA, yDirA;
    logic [9:0] qryXA, qryYA;
    logic       qryVldA;
    logic [2:0] tileA = '0;
    logic       busyA, doneA;
    logic [3:0] colA;

    logic       startB;
    logic [9:0] xPosB, yPosB;
    logic [4:0] xSpdB, ySpdB;
    logic       xDirB, yDirB;
    logic [9:0] qryXB, qryYB;
    logic       qryVldB;
    logic [2:0] tileB = '0;
    logic [2:0] s1B = '0, s2B = '0;
    logic       busyB, doneB;
    logic [3:0] colB;

    box_resolver dutA (
        .clk(clk), .rst(rst), .start(startA),
        .x_pos(xPosA), .y_pos(yPosA),
        .x_spd(xSpdA), .y_spd(ySpdA),
        .x_dir(xDirA), .y_dir(yDirA),
        .qry_x(qryXA), .qry_y(qryYA), .qry_vld(qryVldA),
        .tile_type(tileA),
        .busy(busyA), .done(doneA), .col(colA)
    );

    box_resolver #(
        .BOX_H(64), .NPTS_Y(4), .LOOKUP_LAT(3)
    ) dutB (
        .clk(clk), .rst(rst), .start(startB),
        .x_pos(xPosB), .y_pos(yPosB),
        .x_spd(xSpdB), .y_spd(ySpdB),
        .x_dir(xDirB), .y_dir(yDirB),
        .qry_x(qryXB), .qry_y(qryYB), .qry_vld(qryVldB),
        .tile_type(tileB),
        .busy(busyB), .done(doneB), .col(colB)
    );

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
    } probe_t;

    typedef struct packed {
        logic [3:0]  col;
        logic [31:0] cyc;
    } res_t;

    probe_t prbA[$];
    probe_t prbB[$];
    res_t   resA[$];
    res_t   resB[$];

    int passCnt = 0;
    int failCnt = 0;
    int totalCnt = 0;
    int modeA = 0;
    int sinceA = 0;
    int sinceB = 0;
    int doneCntA = 0;

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        totalCnt++;
        assert (obs === exp) passCnt++;
        else begin
            failCnt++;
            $error("FAIL %s: observed %0d expected %0d",
                   tag, obs, exp);
        end
    endtask

    // Tile map models
    function automatic logic [2:0] mapA(input logic [9:0] x,
                                        input logic [9:0] y);
        case (modeA)
            1: return (x >= 10'd135) ? 3'd1 : 3'd0;
            2: return (y >= 10'd203) ? 3'd2 : 3'd0;
            3: return (y <= 10'd197) ? 3'd2 : 3'd0;
            5: return 3'd1;
            6: begin
                if (x >= 10'd135) return 3'd1;
                if (y >= 10'd203) return 3'd2;
                return 3'd0;
            end
            7: return (x <= 10'd96 || y == 10'd167) ? 3'd1 : 3'd0;
            default: return 3'd0;
        endcase
    endfunction

    always @(posedge clk) tileA <= mapA(qryXA, qryYA);

    always @(posedge clk) begin
        s1B   <= (qryXB == 10'd132 && qryYB == 10'd258) ? 3'd1 : 3'd0;
        s2B   <= s1B;
        tileB <= s2B;
    end

    // Cycle count since accept (accept cycle = 0)
    always @(posedge clk or posedge rst) begin
        if (rst) sinceA = 0;
        else if (startA && !busyA) sinceA = 1;
        else sinceA = sinceA + 1;
    end

    always @(posedge clk or posedge rst) begin
        if (rst) sinceB = 0;
        else if (startB && !busyB) sinceB = 1;
        else sinceB = sinceB + 1;
    end

    // Scoreboard monitors
    always @(negedge clk) begin
        probe_t p;
        res_t   r;
        if (qryVldA) begin
            check("A probe expected", 32'(prbA.size() > 0), 32'd1);
            if (prbA.size() > 0) begin
                p = prbA.pop_front();
                check("A qry_x", 32'(qryXA), 32'(p.x));
                check("A qry_y", 32'(qryYA), 32'(p.y));
            end
        end
        if (doneA) begin
            doneCntA++;
            check("A done expected", 32'(resA.size() > 0), 32'd1);
            if (resA.size() > 0) begin
                r = resA.pop_front();
                check("A col", 32'(colA), 32'(r.col));
                check("A done cycle", 32'(sinceA), r.cyc);
            end
        end
    end

    always @(negedge clk) begin
        probe_t p;
        res_t   r;
        if (qryVldB) begin
            check("B probe expected", 32'(prbB.size() > 0), 32'd1);
            if (prbB.size() > 0) begin
                p = prbB.pop_front();
                check("B qry_x", 32'(qryXB), 32'(p.x));
                check("B qry_y", 32'(qryYB), 32'(p.y));
            end
        end
        if (doneB) begin
            check("B done expected", 32'(resB.size() > 0), 32'd1);
            if (resB.size() > 0) begin
                r = resB.pop_front();
                check("B col", 32'(colB), 32'(r.col));
                check("B done cycle", 32'(sinceB), r.cyc);
            end
        end
    end

    task automatic pA(input logic [9:0] x, input logic [9:0] y);
        prbA.push_back('{x: x, y: y});
    endtask

    task automatic pB(input logic [9:0] x, input logic [9:0] y);
        prbB.push_back('{x: x, y: y});
    endtask

    // Drives one request; returns at the negedge of cycle 1
    task automatic goA(input logic [9:0] xp, input logic [9:0] yp,
                       input logic [4:0] xs, input logic [4:0] ys,
                       input logic xd, input logic yd);
        @(negedge clk);
        xPosA = xp; yPosA = yp; xSpdA = xs; ySpdA = ys;
        xDirA = xd; yDirA = yd; startA = 1'b1;
        @(negedge clk);
        startA = 1'b0;
        xPosA = 10'($urandom); yPosA = 10'($urandom);
        xSpdA = 5'($urandom); ySpdA = 5'($urandom);
        xDirA = 1'($urandom); yDirA = 1'($urandom);
    endtask

    task automatic waitA();
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (resA.size() == 0 && !busyA) break;
        end
        check("A results drained", 32'(resA.size()), 32'd0);
        check("A probes drained", 32'(prbA.size()), 32'd0);
    endtask

    task automatic waitB();
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (resB.size() == 0 && !busyB) break;
        end
        check("B results drained", 32'(resB.size()), 32'd0);
        check("B probes drained", 32'(prbB.size()), 32'd0);
    endtask

    int doneBase;

    initial begin
        rst = 1'b1;
        startA = 1'b0; xPosA = '0; yPosA = '0;
        xSpdA = '0; ySpdA = '0; xDirA = 1'b0; yDirA = 1'b0;
        startB = 1'b0; xPosB = '0; yPosB = '0;
        xSpdB = '0; ySpdB = '0; xDirB = 1'b0; yDirB = 1'b0;
        repeat (2) @(negedge clk);
        check("A reset outputs", 32'({busyA, doneA, colA,
              qryVldA, qryXA, qryYA}), 32'd0);
        check("B reset outputs", 32'({busyB, doneB, colB,
              qryVldB, qryXB, qryYB}), 32'd0);
        rst = 1'b0;

        // Defaults: moving right into solid wall
        modeA = 1;
        pA(135, 200); pA(135, 169);
        resA.push_back('{col: 4'b0100, cyc: 4});
        goA(100, 200, 4, 0, 1'b1, 1'b0);
        waitA();

        // One-way platform, falling onto it
        modeA = 2;
        pA(100, 203); pA(131, 203);
        resA.push_back('{col: 4'b0010, cyc: 4});
        goA(100, 200, 0, 3, 1'b0, 1'b0);
        waitA();

        // One-way platform, moving up through it
        modeA = 3;
        pA(100, 166); pA(131, 166);
        resA.push_back('{col: 4'b0000, cyc: 4});
        goA(100, 200, 0, 3, 1'b0, 1'b1);
        waitA();

        // Wrap-around on the left edge, empty map
        modeA = 0;
        pA(1021, 50); pA(1021, 19);
        resA.push_back('{col: 4'b0000, cyc: 4});
        goA(2, 50, 5, 0, 1'b0, 1'b0);
        waitA();

        // Both passes: right wall and floor
        modeA = 6;
        pA(135, 200); pA(135, 169); pA(100, 203); pA(131, 203);
        resA.push_back('{col: 4'b0110, cyc: 7});
        goA(100, 200, 4, 3, 1'b1, 1'b0);
        waitA();

        // Both passes: left wall and ceiling
        modeA = 7;
        pA(96, 200); pA(96, 169); pA(100, 167); pA(131, 167);
        resA.push_back('{col: 4'b1001, cyc: 7});
        goA(100, 200, 4, 2, 1'b0, 1'b1);
        waitA();

        // Parametrised instance: single hit on the k=2 probe
        pB(132, 300); pB(132, 279); pB(132, 258); pB(132, 237);
        pB(100, 301); pB(131, 301);
        resB.push_back('{col: 4'b0100, cyc: 13});
        @(negedge clk);
        xPosB = 100; yPosB = 300; xSpdB = 1; ySpdB = 1;
        xDirB = 1'b1; yDirB = 1'b0; startB = 1'b1;
        @(negedge clk);
        startB = 1'b0; xPosB = 10'd7; yPosB = 10'd9;
        waitB();

        // Reset during V_ISSUE with a solid reply in flight
        modeA = 5;
        pA(100, 202); pA(131, 202);
        goA(100, 200, 0, 2, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("A outputs in reset", 32'({busyA, doneA, colA,
              qryVldA, qryXA, qryYA}), 32'd0);
        prbA.delete();
        resA.delete();
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check("A stale col", 32'(colA), 32'd0);
        check("A idle after reset", 32'({busyA, qryVldA}), 32'd0);

        // Clean run after reset
        modeA = 1;
        pA(135, 200); pA(135, 169);
        resA.push_back('{col: 4'b0100, cyc: 4});
        goA(100, 200, 4, 0, 1'b1, 1'b0);
        waitA();

        // Zero speed: immediate done, no probes
        modeA = 5;
        resA.push_back('{col: 4'b0000, cyc: 1});
        goA(300, 300, 0, 0, 1'b1, 1'b1);
        waitA();

        // start pulsed while busy is ignored
        modeA = 1;
        doneBase = doneCntA;
        pA(135, 200); pA(135, 169);
        resA.push_back('{col: 4'b0100, cyc: 4});
        goA(100, 200, 4, 0, 1'b1, 1'b0);
        @(negedge clk);
        startA = 1'b1;
        @(negedge clk);
        @(negedge clk);
        startA = 1'b0;
        waitA();
        repeat (6) @(negedge clk);
        check("A single done", 32'(doneCntA - doneBase), 32'd1);
        check("A col held", 32'(colA), 32'd4);

        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule
